// File: rtl/gfx_pkg.sv
// gfx_pkg: shared framebuffer geometry, pixel entry layout and swap FSM states
package gfx_pkg;
  localparam int FB_WIDTH_DEF = 400;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int ADDR_W = 32;
  localparam int COLOR_W = 16;
  localparam int ENTRY_W = ADDR_W + COLOR_W;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } swap_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; head is read combinationally
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // storage needs no reset; stale slots are never visible while empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  // pointers wrap naturally at a power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/framebuffer_sink.sv
// framebuffer_sink: bounds-checks GPU pixels, queues them for memory and owns double buffering
module framebuffer_sink
  import gfx_pkg::*;
#(
  parameter int          FB_WIDTH   = FB_WIDTH_DEF,
  parameter int          FB_HEIGHT  = FB_HEIGHT_DEF,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BUF0_BASE  = 32'h0000_0000,
  parameter logic [31:0] BUF1_BASE  = 32'h0001_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(FB_WIDTH):0]     fb_x,
  input  logic [$clog2(FB_HEIGHT):0]    fb_y,
  input  logic [COLOR_W-1:0]            fb_color,
  input  logic                          fb_write,
  output logic                          fb_stall,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [COLOR_W-1:0]            mem_wdata,
  output logic                          mem_write,
  input  logic                          mem_ready,
  input  logic                          swap_req,
  output logic                          swap_busy,
  output logic                          swap_done,
  output logic                          front_buffer,
  output logic                          overflow,
  input  logic                          clear_overflow
);
  localparam int XW = $clog2(FB_WIDTH) + 1;
  localparam int YW = $clog2(FB_HEIGHT) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic accept, push, pop, full, empty, swap_q;
  logic [CW-1:0] count;
  pix_t entry, head;
  swap_state_t state;
  assign accept = fb_write && fb_x < XW'(FB_WIDTH) && fb_y < YW'(FB_HEIGHT);
  assign pop    = !empty && mem_ready;
  assign push   = accept && (!full || pop);
  assign entry.addr  = (front_buffer ? BUF0_BASE : BUF1_BASE)
                     + 32'(fb_y) * 32'(FB_WIDTH) + 32'(fb_x);
  assign entry.color = fb_color;
  assign mem_write = !empty;
  assign mem_addr  = head.addr;
  assign mem_wdata = head.color;
  assign fb_stall  = count >= CW'(FIFO_DEPTH - 2);
  assign swap_busy = state != RUN;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // sticky drop flag; a drop in the same cycle wins over a clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) overflow <= 1'b0;
    else if (accept && full && !pop) overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;

  // swap FSM: wait for the queue to drain, then flip buffers with a one-cycle done pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= RUN;
      swap_q       <= 1'b0;
      front_buffer <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_q    <= swap_req;
      swap_done <= 1'b0;
      case (state)
        RUN:   if (swap_req && !swap_q) state <= DRAIN;
        DRAIN: if (empty && !push) begin
          state        <= SWAP;
          front_buffer <= ~front_buffer;
          swap_done    <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_framebuffer_sink.sv
// tb_framebuffer_sink: directed vectors with hand-computed expectations
module tb_framebuffer_sink;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [15:0] fb_color;
  logic        fb_write, fb_stall;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write, mem_ready;
  logic        swap_req, swap_busy, swap_done, front_buffer, overflow, clear_overflow;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  framebuffer_sink dut (
    .clk(clk), .reset(reset), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
    .fb_write(fb_write), .fb_stall(fb_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_ready(mem_ready), .swap_req(swap_req), .swap_busy(swap_busy),
    .swap_done(swap_done), .front_buffer(front_buffer), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input logic [15:0] c);
    fb_x = 10'(x);
    fb_y = 9'(y);
    fb_color = c;
    fb_write = 1'b1;
    tick();
    fb_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; fb_x = '0; fb_y = '0; fb_color = '0; fb_write = 1'b0;
    mem_ready = 1'b0; swap_req = 1'b0; clear_overflow = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_front", 32'(front_buffer), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(swap_busy), 0);
    chk("rst_done", 32'(swap_done), 0);
    chk("rst_stall", 32'(fb_stall), 0);

    mem_ready = 1'b1;
    pixel(3, 2, 16'hF801);
    chk("single_write", 32'(mem_write), 1);
    chk("single_addr", mem_addr, 32'h0001_0323);
    chk("single_data", 32'(mem_wdata), 32'hF801);
    tick();
    chk("single_once", 32'(mem_write), 0);

    pixel(400, 0, 16'h1111);
    chk("oob_x_write", 32'(mem_write), 0);
    pixel(0, 240, 16'h2222);
    chk("oob_y_write", 32'(mem_write), 0);
    chk("oob_overflow", 32'(overflow), 0);

    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pixel(i, 0, 16'hA000 + 16'(i));
      chk($sformatf("fill_count%0d", i), 32'(dut.u_fifo.count), (i < 8) ? i + 1 : 8);
      chk($sformatf("fill_stall%0d", i), 32'(fb_stall), (i >= 5) ? 1 : 0);
      chk($sformatf("fill_ovf%0d", i), 32'(overflow), (i >= 8) ? 1 : 0);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_write%0d", k), 32'(mem_write), 1);
      chk($sformatf("drain_addr%0d", k), mem_addr, 32'h0001_0000 + 32'(k));
      chk($sformatf("drain_data%0d", k), 32'(mem_wdata), 32'hA000 + 32'(k));
      tick();
    end
    chk("drain_empty", 32'(mem_write), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) pixel(10 + i, 1, 16'h5000 + 16'(i));
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_busy", 32'(swap_busy), 1);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("swap_addr%0d", k), mem_addr, 32'h0001_019A + 32'(k));
      chk($sformatf("swap_nodone%0d", k), 32'(swap_done), 0);
      tick();
    end
    chk("swap_empty", 32'(mem_write), 0);
    chk("swap_wait", 32'(swap_done), 0);
    tick();
    chk("swap_done", 32'(swap_done), 1);
    chk("swap_front", 32'(front_buffer), 1);
    tick();
    chk("swap_pulse", 32'(swap_done), 0);
    chk("swap_idle", 32'(swap_busy), 0);
    pixel(0, 0, 16'h0F0F);
    chk("newback_write", 32'(mem_write), 1);
    chk("newback_addr", mem_addr, 32'h0000_0000);
    tick();

    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) pixel(20 + i, 0, 16'h7000 + 16'(i));
    chk("full_count", 32'(dut.u_fifo.count), 8);
    mem_ready = 1'b1;
    pixel(50, 0, 16'h7777);
    chk("pp_count", 32'(dut.u_fifo.count), 8);
    chk("pp_overflow", 32'(overflow), 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("pp_addr%0d", k), mem_addr, (k < 7) ? 32'(21 + k) : 32'd50);
      tick();
    end
    chk("pp_empty", 32'(mem_write), 0);

    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) pixel(i, 3, 16'h3000 + 16'(i));
    chk("pre_rst_write", 32'(mem_write), 1);
    chk("pre_rst_front", 32'(front_buffer), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_write", 32'(mem_write), 0);
    chk("async_rst_front", 32'(front_buffer), 0);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_write", 32'(mem_write), 0);
    chk("post_rst_count", 32'(dut.u_fifo.count), 0);
    pixel(5, 5, 16'hBEEF);
    chk("post_rst_addr", mem_addr, 32'h0001_07D5);
    chk("post_rst_data", 32'(mem_wdata), 32'hBEEF);
    tick();
    chk("post_rst_done", 32'(mem_write), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/framebuffer_sink.md
Name: framebuffer_sink

Overview:
- Write-side endpoint of the GPU pixel interface (fb_x, fb_y, fb_color, fb_write).
- Bounds-checks each pixel and converts it to a linear framebuffer address. Buffers pixels in a small FIFO and retires them to a 16-bit memory write port with a ready handshake.
- Owns double-buffer state: which buffer is displayed (front) and which the GPU draws into (back). Swaps on request only after all pending pixels are retired.

Parameters:
- FB_WIDTH, 400, framebuffer width in pixels.
- FB_HEIGHT, 240, framebuffer height in pixels.
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, minimum 4.
- BUF0_BASE, 32'h0000_0000, word address of buffer 0.
- BUF1_BASE, 32'h0001_0000, word address of buffer 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fb_x  in  $clog2(FB_WIDTH)+1  pixel x coordinate.
- fb_y  in  $clog2(FB_HEIGHT)+1  pixel y coordinate.
- fb_color  in  16  pixel colour, passed through unchanged.
- fb_write  in  1  pixel valid this cycle; no backpressure at the source.
- fb_stall  out  1  FIFO count >= FIFO_DEPTH-2; advisory only.
- mem_addr  out  32  word address of the FIFO head.
- mem_wdata  out  16  colour of the FIFO head.
- mem_write  out  1  FIFO not empty.
- mem_ready  in  1  memory accepts the head this cycle.
- swap_req  in  1  rising edge requests a buffer swap.
- swap_busy  out  1  swap pending (state != RUN).
- swap_done  out  1  one-cycle pulse when the swap takes effect.
- front_buffer  out  1  index of the displayed buffer.
- overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full.
- clear_overflow  in  1  clears overflow (level-sensitive).

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; mem_write=0.
  - front_buffer=0, so the back buffer is BUF1_BASE.
  - overflow=0, swap_done=0, fb_stall=0, state=RUN, swap_req edge register=0.
- Accept condition: fb_write && fb_x<FB_WIDTH && fb_y<FB_HEIGHT (unsigned compare). Out-of-bounds pixels are silently discarded and do not set overflow.
- Address:
  - addr = back_base + fb_y*FB_WIDTH + fb_x, computed at 32 bits and registered into the FIFO entry.
  - back_base = front_buffer ? BUF0_BASE : BUF1_BASE, sampled in the accept cycle.
- Push: accept && (!full || pop). When full and no pop in the same cycle, the pixel is dropped and overflow is set.
- Pop: mem_write && mem_ready.
- Memory port: mem_addr and mem_wdata are driven combinationally from the head. They hold stable while mem_write=1 and mem_ready=0.
- Latency: a pixel accepted in cycle t appears on the memory port in cycle t+1 if the FIFO was empty. Throughput is 1 pixel/cycle when mem_ready is held high.
- Ordering: strict FIFO order; no write merging.
- Simultaneous push and pop at count 1 or full: count is unchanged and the head advances.
- Count width: $clog2(FIFO_DEPTH)+1 bits. Read and write pointers wrap modulo FIFO_DEPTH.
- overflow: set has priority over clear_overflow in the same cycle.
- Swap FSM:
  - RUN: on a swap_req rising edge, go to DRAIN; swap_busy=1.
  - DRAIN: pixels are still accepted and addressed to the current back buffer. When the FIFO is empty and no push happens this cycle, go to SWAP.
  - SWAP: toggle front_buffer, pulse swap_done for one cycle, return to RUN.
  - A swap_req edge while not in RUN is ignored.
- The first pixel accepted after swap_done uses the new back buffer.
- Reset asserted mid-operation: pending pixels are lost; mem_write falls asynchronously.

Decomposition:
- Shared package (gfx_pkg):
  - FSM state constants: RUN=0, DRAIN=1, SWAP=2.
  - FB_WIDTH and FB_HEIGHT defaults, shared with GPU.
  - Pixel-entry field widths: 32-bit address, 16-bit colour.
- One sub-module: sync_fifo.
  - Parameterised width and depth; async active-low reset.
  - Provides push, pop, full, empty and count.
  - Instantiated with a 48-bit entry.

Test Plan:
- Single pixel (x=3, y=2, colour 16'hF801, mem_ready=1) after reset -> next cycle mem_addr=32'h0001_0323 (BUF1_BASE+803), mem_wdata=16'hF801, mem_write=1 for exactly one cycle.
- Out-of-bounds pixels (x=400, y=0) and (x=0, y=240) -> mem_write never asserts and overflow stays 0.
- mem_ready=0 while 10 consecutive pixels arrive:
  - fb_stall rises at count 6.
  - Pixels 9 and 10 are dropped and overflow=1.
  - Releasing mem_ready retires exactly 8 writes in order.
  - clear_overflow clears the flag.
- swap_req pulse with 3 pixels queued and mem_ready=1 -> swap_busy=1, the 3 writes use BUF1_BASE, swap_done pulses the cycle after the FIFO empties, front_buffer=1, and the next pixel (0,0) targets 32'h0000_0000.
- Full FIFO with push and pop in the same cycle -> count stays 8, no drop, overflow stays 0.
- reset asserted with 5 entries queued -> mem_write=0 immediately; after release, front_buffer=0 and no stale writes appear.
